// File: rtl/omr_pkg.sv
// Shared types, state codes and width helpers for the streaming OMR grader.
package omr_pkg;

    localparam logic [1:0] LOAD_KEY = 2'd0;
    localparam logic [1:0] GRADE    = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;

    typedef enum logic [1:0] {
        CORRECT,
        WRONG,
        BLANK
    } ans_class_e;

    localparam logic [31:0] BLANK_CODE = '0;

    function automatic int unsigned cnt_width(input int unsigned num_q);
        return $clog2(num_q + 1);
    endfunction

    // Never returns 0, so a POS_MARK of 0 still yields a legal port width.
    function automatic int unsigned score_width(input int unsigned num_q,
                                                input int unsigned pos_mark);
        int unsigned w;
        w = $clog2(num_q * pos_mark + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/omr_stream_grader_if.sv
// Key-load, answer-stream and result handshakes of the OMR grader.
interface omr_stream_grader_if #(
    parameter int unsigned OPT_W   = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned SCORE_W = 4
);
    logic               key_reload;
    logic               key_valid;
    logic [OPT_W-1:0]   key_data;
    logic               key_ready;
    logic               key_loaded;
    logic               ans_valid;
    logic [OPT_W-1:0]   ans_data;
    logic               ans_ready;
    logic               res_valid;
    logic               res_ready;
    logic [SCORE_W-1:0] score;
    logic [CNT_W-1:0]   correct_cnt;
    logic [CNT_W-1:0]   wrong_cnt;
    logic [CNT_W-1:0]   blank_cnt;

    modport master (
        output key_reload, key_valid, key_data, ans_valid, ans_data, res_ready,
        input  key_ready, key_loaded, ans_ready, res_valid, score,
               correct_cnt, wrong_cnt, blank_cnt
    );

    modport slave (
        input  key_reload, key_valid, key_data, ans_valid, ans_data, res_ready,
        output key_ready, key_loaded, ans_ready, res_valid, score,
               correct_cnt, wrong_cnt, blank_cnt
    );
endinterface

// File: rtl/omr_answer_classifier.sv
// Classifies one marked answer against its key entry; a zero key voids the question.
module omr_answer_classifier
    import omr_pkg::*;
#(
    parameter int unsigned OPT_W = 4
) (
    input  logic [OPT_W-1:0] key,
    input  logic [OPT_W-1:0] ans,
    output ans_class_e       ans_class
);

    always_comb begin
        if (key == OPT_W'(BLANK_CODE)) begin
            ans_class = CORRECT;
        end else if (ans == OPT_W'(BLANK_CODE)) begin
            ans_class = BLANK;
        end else if (ans == key) begin
            ans_class = CORRECT;
        end else begin
            ans_class = WRONG;
        end
    end

endmodule

// File: rtl/omr_stream_grader.sv
// Streaming OMR grader: loads a key once, then grades sheets one answer per cycle
// and reports a clamped weighted score per sheet.
module omr_stream_grader
    import omr_pkg::*;
#(
    parameter int unsigned NUM_Q    = 10,
    parameter int unsigned OPT_W    = 4,
    parameter int unsigned POS_MARK = 1,
    parameter int unsigned NEG_MARK = 1,
    parameter int unsigned CNT_W    = cnt_width(NUM_Q),
    parameter int unsigned SCORE_W  = score_width(NUM_Q, POS_MARK)
) (
    input logic                clk,
    input logic                reset_n,
    omr_stream_grader_if.slave bus
);

    localparam int unsigned IDX_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int unsigned CALC_W = SCORE_W + CNT_W + $clog2(NEG_MARK + 1) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_Q - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               key_loaded_q, key_loaded_d;
    logic               res_valid_q, res_valid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   correct_q, correct_d;
    logic [CNT_W-1:0]   wrong_q, wrong_d;
    logic [CNT_W-1:0]   blank_q, blank_d;
    logic [OPT_W-1:0]   key_mem_q [NUM_Q];
    logic [CALC_W-1:0]  pos_sum, neg_sum;
    logic               key_xfer, ans_xfer;
    ans_class_e         ans_class;

    omr_answer_classifier #(
        .OPT_W(OPT_W)
    ) u_classifier (
        .key      (key_mem_q[idx_q]),
        .ans      (bus.ans_data),
        .ans_class(ans_class)
    );

    assign key_xfer = (state_q == LOAD_KEY) && bus.key_valid && !bus.key_reload;
    assign ans_xfer = (state_q == GRADE) && bus.ans_valid && !bus.key_reload;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        key_loaded_d = key_loaded_q;
        res_valid_d  = res_valid_q;
        score_d      = score_q;
        correct_d    = correct_q;
        wrong_d      = wrong_q;
        blank_d      = blank_q;

        if (bus.key_reload) begin
            state_d      = LOAD_KEY;
            idx_d        = '0;
            key_loaded_d = 1'b0;
            res_valid_d  = 1'b0;
            score_d      = '0;
            correct_d    = '0;
            wrong_d      = '0;
            blank_d      = '0;
        end else begin
            case (state_q)
                LOAD_KEY: begin
                    if (key_xfer) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d        = '0;
                            key_loaded_d = 1'b1;
                            state_d      = GRADE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                GRADE: begin
                    if (ans_xfer) begin
                        unique case (ans_class)
                            CORRECT: correct_d = correct_q + CNT_W'(1);
                            WRONG:   wrong_d   = wrong_q + CNT_W'(1);
                            BLANK:   blank_d   = blank_q + CNT_W'(1);
                            default: ;
                        endcase
                        if (idx_q == LAST_IDX) begin
                            idx_d       = '0;
                            state_d     = DONE;
                            res_valid_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_d     = GRADE;
                        res_valid_d = 1'b0;
                        score_d     = '0;
                        correct_d   = '0;
                        wrong_d     = '0;
                        blank_d     = '0;
                    end
                end
                default: state_d = LOAD_KEY;
            endcase
        end

        // Score is taken from the post-increment counts so it lands with res_valid.
        pos_sum = CALC_W'(correct_d) * CALC_W'(POS_MARK);
        neg_sum = CALC_W'(wrong_d) * CALC_W'(NEG_MARK);
        if (ans_xfer && (idx_q == LAST_IDX)) begin
            score_d = (pos_sum >= neg_sum) ? SCORE_W'(pos_sum - neg_sum) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LOAD_KEY;
            idx_q        <= '0;
            key_loaded_q <= 1'b0;
            res_valid_q  <= 1'b0;
            score_q      <= '0;
            correct_q    <= '0;
            wrong_q      <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            key_loaded_q <= key_loaded_d;
            res_valid_q  <= res_valid_d;
            score_q      <= score_d;
            correct_q    <= correct_d;
            wrong_q      <= wrong_d;
            blank_q      <= blank_d;
        end
    end

    // Key storage survives reset; only the loaded flag is cleared.
    always_ff @(posedge clk) begin
        if (reset_n && key_xfer) begin
            key_mem_q[idx_q] <= bus.key_data;
        end
    end

    assign bus.key_ready   = (state_q == LOAD_KEY);
    assign bus.ans_ready   = (state_q == GRADE) && !bus.key_reload;
    assign bus.key_loaded  = key_loaded_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.score       = score_q;
    assign bus.correct_cnt = correct_q;
    assign bus.wrong_cnt   = wrong_q;
    assign bus.blank_cnt   = blank_q;

endmodule
